program_counter: RTL and testbench

//   Fetch-stage program counter for the core. Holds the current PC and run state.

---
 rtl/program_counter.sv | 104 ++++++++++
 tb/tb_program_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Fetch-stage program counter: holds the PC and run state, steps by +1 or a
// signed relative branch offset, and counts retired instructions (saturating).
module program_counter #(
  parameter int PC_WIDTH    = 10,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   halt,
  input  logic                   branch_en,
  input  logic                   branch_taken,
  input  logic [7:0]             offset,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   running,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  state_t state;

  // Sign-extend the 8-bit table offset to the PC width; the add then wraps modulo 2**PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] sext_offset(input logic [7:0] off);
    return PC_WIDTH'($signed(off));
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] cnt);
    return (cnt == COUNT_MAX) ? cnt : cnt + COUNT_WIDTH'(1);
  endfunction

  // State, PC, retired counter and status flags, all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= {PC_WIDTH{1'b0}};
      retired <= {COUNT_WIDTH{1'b0}};
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            pc      <= {PC_WIDTH{1'b0}};
            retired <= {COUNT_WIDTH{1'b0}};
            running <= 1'b1;
            done    <= 1'b0;
          end else begin
            state   <= state;
            pc      <= pc;
            retired <= retired;
            running <= 1'b0;
            done    <= (state == DONE);
          end
        end
        RUN: begin
          if (stall) begin
            state   <= RUN;
            pc      <= pc;
            retired <= retired;
            running <= 1'b1;
            done    <= 1'b0;
          end else if (halt) begin
            // PC stays on the halt instruction so the host can see where it stopped.
            state   <= DONE;
            pc      <= pc;
            retired <= sat_inc(retired);
            running <= 1'b0;
            done    <= 1'b1;
          end else if (branch_en && branch_taken) begin
            state   <= RUN;
            pc      <= pc + sext_offset(offset);
            retired <= sat_inc(retired);
            running <= 1'b1;
            done    <= 1'b0;
          end else begin
            state   <= RUN;
            pc      <= pc + PC_WIDTH'(1);
            retired <= sat_inc(retired);
            running <= 1'b1;
            done    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          pc      <= {PC_WIDTH{1'b0}};
          retired <= {COUNT_WIDTH{1'b0}};
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Randomised + directed bench for program_counter: a second instance with a
// 4-bit retired counter exercises saturation alongside the default instance.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        branch_en = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  offset = 8'd0;

  logic [9:0]  pc, pc4;
  logic        running, done, running4, done4;
  logic [15:0] retired;
  logic [3:0]  retired4;

  int n_cmp = 0;
  int n_mis = 0;
  bit checking = 1'b0;

  // Reference model: state 0=idle 1=run 2=done
  int m_state = 0;
  int m_pc = 0;
  int m_ret = 0;
  int m_ret4 = 0;

  always #5 clk = ~clk;

  program_counter #(.PC_WIDTH(10), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_taken(branch_taken), .offset(offset),
    .pc(pc), .running(running), .done(done), .retired(retired)
  );

  program_counter #(.PC_WIDTH(10), .COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_taken(branch_taken), .offset(offset),
    .pc(pc4), .running(running4), .done(done4), .retired(retired4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the architectural rules, using plain integer arithmetic.
  always @(posedge clk) begin
    if (reset) begin
      m_state <= 0; m_pc <= 0; m_ret <= 0; m_ret4 <= 0;
    end else if (m_state != 1) begin
      if (start) begin
        m_state <= 1; m_pc <= 0; m_ret <= 0; m_ret4 <= 0;
      end
    end else if (!stall) begin
      m_ret  <= (m_ret  < 65535) ? m_ret + 1  : m_ret;
      m_ret4 <= (m_ret4 < 15)    ? m_ret4 + 1 : m_ret4;
      if (halt)
        m_state <= 2;
      else if (branch_en && branch_taken)
        m_pc <= (m_pc + int'($signed(offset)) + 1024) % 1024;
      else
        m_pc <= (m_pc + 1) % 1024;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("pc", 32'(pc), 32'(m_pc));
      check("running", 32'(running), 32'(m_state == 1));
      check("done", 32'(done), 32'(m_state == 2));
      check("retired", 32'(retired), 32'(m_ret));
      check("pc_sat", 32'(pc4), 32'(m_pc));
      check("retired_sat", 32'(retired4), 32'(m_ret4));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic plain();
    start = 1'b0; stall = 1'b0; halt = 1'b0; branch_en = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic branch(input logic [7:0] off);
    plain();
    branch_en = 1'b1; branch_taken = 1'b1; offset = off;
    step();
  endtask

  initial begin
    // 1. reset, start, three plain cycles
    reset = 1'b1; plain();
    step(); step();
    checking = 1'b1;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    reset = 1'b0; start = 1'b1;
    step();
    check("start_pc", 32'(pc), 32'd0);
    check("start_running", 32'(running), 32'd1);
    plain();
    repeat (3) step();
    check("plain_pc", 32'(pc), 32'd3);
    check("plain_retired", 32'(retired), 32'd3);

    // 2. relative branches
    branch(8'h64);
    check("br_fwd_pc", 32'(pc), 32'd103);
    branch(8'hE2);
    check("br_back_pc", 32'(pc), 32'd73);
    plain(); branch_en = 1'b1; branch_taken = 1'b0; offset = 8'h40;
    step();
    check("br_nt_pc", 32'(pc), 32'd74);
    check("br_retired", 32'(retired), 32'd6);

    // 3. wrap both ways (74 + 7*127 + 60 = 1023)
    repeat (7) branch(8'h7F);
    branch(8'h3C);
    check("to_max_pc", 32'(pc), 32'd1023);
    plain(); step();
    check("wrap_up_pc", 32'(pc), 32'd0);
    branch(8'hFF);
    check("wrap_down_pc", 32'(pc), 32'd1023);
    branch(8'h00);
    check("self_loop_pc", 32'(pc), 32'd1023);
    check("self_loop_retired", 32'(retired), 32'd17);

    // 4. stall beats halt and branch; then halt
    plain(); stall = 1'b1; halt = 1'b1; branch_en = 1'b1; branch_taken = 1'b1; offset = 8'h05;
    step();
    check("stall_pc", 32'(pc), 32'd1023);
    check("stall_retired", 32'(retired), 32'd17);
    check("stall_running", 32'(running), 32'd1);
    stall = 1'b0;
    step();
    check("halt_done", 32'(done), 32'd1);
    check("halt_running", 32'(running), 32'd0);
    check("halt_pc", 32'(pc), 32'd1023);
    check("halt_retired", 32'(retired), 32'd18);
    plain(); branch_en = 1'b1; branch_taken = 1'b1; offset = 8'h10;
    repeat (3) step();
    check("done_hold_pc", 32'(pc), 32'd1023);
    check("done_hold_retired", 32'(retired), 32'd18);

    // 5/6. restart, saturate the 4-bit counter, reset mid-run at pc 40
    plain(); start = 1'b1;
    step();
    check("restart_pc", 32'(pc), 32'd0);
    check("restart_retired", 32'(retired), 32'd0);
    check("restart_running", 32'(running), 32'd1);
    plain();
    repeat (20) step();
    check("sat_retired", 32'(retired4), 32'd15);
    check("nosat_retired", 32'(retired), 32'd20);
    repeat (20) step();
    check("pc40", 32'(pc), 32'd40);
    reset = 1'b1; branch_en = 1'b1; branch_taken = 1'b1; offset = 8'h20;
    step();
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_retired", 32'(retired), 32'd0);

    // Random phase, checked cycle-by-cycle by the model
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      start        = ($urandom_range(0, 7) == 0);
      stall        = ($urandom_range(0, 4) == 0);
      halt         = ($urandom_range(0, 29) == 0);
      branch_en    = ($urandom_range(0, 2) == 0);
      branch_taken = $urandom_range(0, 1) != 0;
      offset       = 8'($urandom);
      step();
    end

    checking = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
